// File: rtl/sram_reg_port_arb.sv
// rtl/sram_reg_port_arb.sv - register/datapath SRAM access arbiter with read-tag return
// Define SRAM_ARB_REG_PRIORITY_EN for strict register priority; default is weighted round-robin.
module sram_reg_port_arb #(
  parameter int SRAM_ADDR_WIDTH = 19,
  parameter int SRAM_DATA_WIDTH = 36,
  parameter int RD_LATENCY      = 4,
  parameter int DP_WEIGHT       = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       reg_rd_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] reg_rd_addr,
  output logic                       reg_rd_ack,
  input  logic                       reg_wr_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] reg_wr_addr,
  input  logic [SRAM_DATA_WIDTH-1:0] reg_wr_data,
  output logic                       reg_wr_ack,
  input  logic                       dp_rd_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] dp_rd_addr,
  output logic                       dp_rd_ack,
  input  logic                       dp_wr_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] dp_wr_addr,
  input  logic [SRAM_DATA_WIDTH-1:0] dp_wr_data,
  output logic                       dp_wr_ack,
  output logic [SRAM_DATA_WIDTH-1:0] rd_data,
  output logic                       reg_rd_vld,
  output logic                       dp_rd_vld,
  output logic                       sram_req,
  output logic                       sram_we,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [SRAM_DATA_WIDTH-1:0] sram_wr_data,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_data
);

  logic reg_rd_elig, reg_wr_elig, dp_rd_elig, dp_wr_elig;
  logic reg_elig, dp_elig;
  logic grant_reg, grant_dp, grant_any, issue_rd;
  logic [SRAM_ADDR_WIDTH-1:0] issue_addr;
  logic [SRAM_DATA_WIDTH-1:0] issue_data;
  logic [RD_LATENCY:0]        tag_vld;
  logic [RD_LATENCY:0]        tag_own;

  // A request seen together with its own ack is the one just issued; the requester drops it next cycle.
  assign reg_rd_elig = reg_rd_req & ~reg_rd_ack;
  assign reg_wr_elig = reg_wr_req & ~reg_wr_ack;
  assign dp_rd_elig  = dp_rd_req  & ~dp_rd_ack;
  assign dp_wr_elig  = dp_wr_req  & ~dp_wr_ack;
  assign reg_elig    = reg_rd_elig | reg_wr_elig;
  assign dp_elig     = dp_rd_elig  | dp_wr_elig;

`ifdef SRAM_ARB_REG_PRIORITY_EN
  always_comb begin
    grant_reg = reg_elig;
    grant_dp  = dp_elig & ~reg_elig;
  end
`else
  logic [3:0] dp_run;

  always_comb begin
    grant_reg = 1'b0;
    grant_dp  = 1'b0;
    if (dp_elig && (!reg_elig || dp_run < 4'(DP_WEIGHT))) begin
      grant_dp = 1'b1;
    end else if (reg_elig) begin
      grant_reg = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dp_run <= 4'd0;
    end else if (grant_dp) begin
      if (dp_run != 4'hF) dp_run <= dp_run + 4'd1;
    end else if (grant_reg) begin
      dp_run <= 4'd0;
    end
  end
`endif

  assign grant_any = grant_reg | grant_dp;

  always_comb begin
    issue_rd   = 1'b0;
    issue_addr = '0;
    issue_data = '0;
    if (grant_reg) begin
      issue_rd   = reg_rd_elig;
      issue_addr = reg_rd_elig ? reg_rd_addr : reg_wr_addr;
      issue_data = reg_wr_data;
    end else if (grant_dp) begin
      issue_rd   = dp_rd_elig;
      issue_addr = dp_rd_elig ? dp_rd_addr : dp_wr_addr;
      issue_data = dp_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_rd_ack   <= 1'b0;
      reg_wr_ack   <= 1'b0;
      dp_rd_ack    <= 1'b0;
      dp_wr_ack    <= 1'b0;
      sram_req     <= 1'b0;
      sram_we      <= 1'b0;
      sram_addr    <= '0;
      sram_wr_data <= '0;
      tag_vld      <= '0;
      tag_own      <= '0;
      reg_rd_vld   <= 1'b0;
      dp_rd_vld    <= 1'b0;
      rd_data      <= '0;
    end else begin
      reg_rd_ack <= grant_reg & issue_rd;
      reg_wr_ack <= grant_reg & ~issue_rd;
      dp_rd_ack  <= grant_dp & issue_rd;
      dp_wr_ack  <= grant_dp & ~issue_rd;
      sram_req   <= grant_any;
      sram_we    <= grant_any & ~issue_rd;
      if (grant_any) begin
        sram_addr <= issue_addr;
        if (!issue_rd) sram_wr_data <= issue_data;
      end
      // Stage k describes the read issued k cycles ago; the last stage lines up with its data.
      tag_vld <= {tag_vld[RD_LATENCY-1:0], grant_any & issue_rd};
      tag_own <= {tag_own[RD_LATENCY-1:0], grant_dp};
      reg_rd_vld <= tag_vld[RD_LATENCY] & ~tag_own[RD_LATENCY];
      dp_rd_vld  <= tag_vld[RD_LATENCY] &  tag_own[RD_LATENCY];
      if (tag_vld[RD_LATENCY]) rd_data <= sram_rd_data;
    end
  end

endmodule

// File: tb/tb_sram_reg_port_arb.sv
// tb/tb_sram_reg_port_arb.sv - directed self-checking bench for sram_reg_port_arb
module tb_sram_reg_port_arb;
  localparam int AW = 19;
  localparam int DW = 36;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          reg_rd_req = 1'b0, reg_wr_req = 1'b0, dp_rd_req = 1'b0, dp_wr_req = 1'b0;
  logic [AW-1:0] reg_rd_addr = '0, reg_wr_addr = '0, dp_rd_addr = '0, dp_wr_addr = '0;
  logic [DW-1:0] reg_wr_data = '0, dp_wr_data = '0, sram_rd_data = '0;
  logic          reg_rd_ack, reg_wr_ack, dp_rd_ack, dp_wr_ack;
  logic          reg_rd_vld, dp_rd_vld, sram_req, sram_we;
  logic [DW-1:0] rd_data, sram_wr_data;
  logic [AW-1:0] sram_addr;

  int n_cmp = 0;
  int n_err = 0;

  sram_reg_port_arb dut (
    .clk(clk), .reset(reset),
    .reg_rd_req(reg_rd_req), .reg_rd_addr(reg_rd_addr), .reg_rd_ack(reg_rd_ack),
    .reg_wr_req(reg_wr_req), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .reg_wr_ack(reg_wr_ack),
    .dp_rd_req(dp_rd_req), .dp_rd_addr(dp_rd_addr), .dp_rd_ack(dp_rd_ack),
    .dp_wr_req(dp_wr_req), .dp_wr_addr(dp_wr_addr), .dp_wr_data(dp_wr_data), .dp_wr_ack(dp_wr_ack),
    .rd_data(rd_data), .reg_rd_vld(reg_rd_vld), .dp_rd_vld(dp_rd_vld),
    .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wr_data(sram_wr_data), .sram_rd_data(sram_rd_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    n_cmp++;
    if ({reg_rd_ack, reg_wr_ack, dp_rd_ack, dp_wr_ack, reg_rd_vld, dp_rd_vld, sram_req, sram_we} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 00000000",
               {reg_rd_ack, reg_wr_ack, dp_rd_ack, dp_wr_ack, reg_rd_vld, dp_rd_vld, sram_req, sram_we});
    end
    n_cmp++;
    if ({sram_addr, sram_wr_data, rd_data} !== '0) begin
      n_err++;
      $display("FAIL reset_data: addr %h wdata %h rdata %h want 0", sram_addr, sram_wr_data, rd_data);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_reg_read();
    reg_rd_addr = 19'h00012;
    reg_rd_req  = 1'b1;
    step();
    n_cmp++;
    if ({reg_rd_ack, sram_req, sram_we} !== 3'b110 || sram_addr !== 19'h00012) begin
      n_err++;
      $display("FAIL rd_issue: ack/req/we %b addr %h want 110 00012", {reg_rd_ack, sram_req, sram_we}, sram_addr);
    end
    step();
    reg_rd_req = 1'b0;
    n_cmp++;
    if ({reg_rd_ack, sram_req} !== 2'b00) begin
      n_err++;
      $display("FAIL rd_no_double: ack/req %b want 00", {reg_rd_ack, sram_req});
    end
    step();
    step();
    step();
    sram_rd_data = 36'h9_DEADBEEF;
    n_cmp++;
    if (reg_rd_vld !== 1'b0) begin
      n_err++;
      $display("FAIL rd_early_vld: got %b want 0", reg_rd_vld);
    end
    step();
    n_cmp++;
    if ({reg_rd_vld, dp_rd_vld} !== 2'b10 || rd_data !== 36'h9_DEADBEEF) begin
      n_err++;
      $display("FAIL rd_return: vld %b data %h want 10 9deadbeef", {reg_rd_vld, dp_rd_vld}, rd_data);
    end
    sram_rd_data = 36'h0_00000123;
    step();
    n_cmp++;
    if ({reg_rd_vld, dp_rd_vld} !== 2'b00 || rd_data !== 36'h9_DEADBEEF) begin
      n_err++;
      $display("FAIL rd_hold: vld %b data %h want 00 9deadbeef", {reg_rd_vld, dp_rd_vld}, rd_data);
    end
  endtask

  task automatic test_reg_write();
    int n_req = 0;
    int n_ack = 0;
    logic prev_ack = 1'b0;
    reg_wr_addr = 19'h7FFFF;
    reg_wr_data = 36'hF_FFFFFFFF;
    reg_wr_req  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (sram_req) begin
        n_req++;
        n_cmp++;
        if (sram_we !== 1'b1 || sram_addr !== 19'h7FFFF || sram_wr_data !== 36'hF_FFFFFFFF) begin
          n_err++;
          $display("FAIL wr_fields: we %b addr %h data %h want 1 7ffff fffffffff", sram_we, sram_addr, sram_wr_data);
        end
      end
      if (reg_wr_ack) n_ack++;
      if (prev_ack) reg_wr_req = 1'b0;
      prev_ack = reg_wr_ack;
    end
    n_cmp++;
    if (n_req != 1 || n_ack != 1) begin
      n_err++;
      $display("FAIL wr_once: sram_req count %0d ack count %0d want 1 1", n_req, n_ack);
    end
  endtask

  task automatic test_weighted();
    int exp_grant[16];
    int exp_vld[16];
    int got_grant;
    int got_vld;
    for (int i = 0; i < 16; i++) begin
      exp_grant[i] = 0;
      exp_vld[i]   = 0;
    end
`ifdef SRAM_ARB_REG_PRIORITY_EN
    for (int i = 1; i <= 10; i++) exp_grant[i] = 1;
    exp_vld[6] = 1; exp_vld[8] = 1; exp_vld[10] = 1; exp_vld[12] = 1; exp_vld[14] = 1;
`else
    for (int i = 1; i <= 10; i++) exp_grant[i] = (i % 5 == 0) ? 1 : 2;
    exp_vld[6] = 2; exp_vld[8] = 2; exp_vld[10] = 1; exp_vld[11] = 2; exp_vld[13] = 2; exp_vld[15] = 1;
`endif
    reset = 1'b0;
    step();
    reset = 1'b1;
    sram_rd_data = '0;
    reg_rd_addr = 19'h00001; reg_wr_addr = 19'h00002; dp_rd_addr = 19'h00003; dp_wr_addr = 19'h00004;
    reg_rd_req = 1'b1; reg_wr_req = 1'b1; dp_rd_req = 1'b1; dp_wr_req = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      step();
      got_grant = (reg_rd_ack | reg_wr_ack) ? 1 : ((dp_rd_ack | dp_wr_ack) ? 2 : 0);
      got_vld   = reg_rd_vld ? 1 : (dp_rd_vld ? 2 : 0);
      n_cmp++;
      if (got_grant != exp_grant[c] || sram_req !== (exp_grant[c] != 0)) begin
        n_err++;
        $display("FAIL arb_grant c%0d: owner %0d req %b want %0d", c, got_grant, sram_req, exp_grant[c]);
      end
      n_cmp++;
      if (got_vld != exp_vld[c] || (exp_vld[c] != 0 && rd_data !== DW'(c - 1))) begin
        n_err++;
        $display("FAIL arb_vld c%0d: owner %0d data %h want %0d %h", c, got_vld, rd_data, exp_vld[c], DW'(c - 1));
      end
      sram_rd_data = DW'(c);
      if (c == 10) begin
        reg_rd_req = 1'b0; reg_wr_req = 1'b0; dp_rd_req = 1'b0; dp_wr_req = 1'b0;
      end
    end
  endtask

  task automatic test_dp_rd_wr();
    dp_rd_addr = 19'h00100;
    dp_wr_addr = 19'h00200;
    dp_wr_data = 36'h0_00000005;
    dp_rd_req  = 1'b1;
    dp_wr_req  = 1'b1;
    step();
    n_cmp++;
    if ({dp_rd_ack, dp_wr_ack, sram_we} !== 3'b100 || sram_addr !== 19'h00100) begin
      n_err++;
      $display("FAIL dp_rd_first: rdack/wrack/we %b addr %h want 100 00100", {dp_rd_ack, dp_wr_ack, sram_we}, sram_addr);
    end
    step();
    dp_rd_req = 1'b0;
    n_cmp++;
    if ({dp_rd_ack, dp_wr_ack, sram_we} !== 3'b011 || sram_addr !== 19'h00200 || sram_wr_data !== 36'h5) begin
      n_err++;
      $display("FAIL dp_wr_next: rdack/wrack/we %b addr %h data %h want 011 00200 5",
               {dp_rd_ack, dp_wr_ack, sram_we}, sram_addr, sram_wr_data);
    end
    step();
    dp_wr_req = 1'b0;
    n_cmp++;
    if (sram_req !== 1'b0 || sram_addr !== 19'h00200) begin
      n_err++;
      $display("FAIL dp_idle_hold: req %b addr %h want 0 00200", sram_req, sram_addr);
    end
  endtask

  task automatic test_reset_mid();
    reg_rd_addr = 19'h00033;
    reg_rd_req  = 1'b1;
    step();
    n_cmp++;
    if (reg_rd_ack !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre_issue: ack %b want 1", reg_rd_ack);
    end
    step();
    reg_rd_req = 1'b0;
    step();
    reset = 1'b0;
    reg_wr_addr = 19'h00044;
    reg_wr_data = 36'h0_000000AB;
    reg_wr_req  = 1'b1;
    #1;
    n_cmp++;
    if ({reg_rd_ack, reg_wr_ack, dp_rd_ack, dp_wr_ack, reg_rd_vld, dp_rd_vld, sram_req, sram_we} !== 8'h00 ||
        {sram_addr, sram_wr_data, rd_data} !== '0) begin
      n_err++;
      $display("FAIL rst_async: ctrl %b addr %h wdata %h rdata %h want all 0",
               {reg_rd_ack, reg_wr_ack, dp_rd_ack, dp_wr_ack, reg_rd_vld, dp_rd_vld, sram_req, sram_we},
               sram_addr, sram_wr_data, rd_data);
    end
    step();
    n_cmp++;
    if ({reg_wr_ack, sram_req, sram_addr} !== '0) begin
      n_err++;
      $display("FAIL rst_held: ack %b req %b addr %h want 0 0 0", reg_wr_ack, sram_req, sram_addr);
    end
    step();
    reset = 1'b1;
    step();
    n_cmp++;
    if ({reg_wr_ack, sram_req, sram_we} !== 3'b111 || sram_addr !== 19'h00044 || sram_wr_data !== 36'hAB) begin
      n_err++;
      $display("FAIL rst_rearb: ack/req/we %b addr %h data %h want 111 00044 ab",
               {reg_wr_ack, sram_req, sram_we}, sram_addr, sram_wr_data);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({reg_rd_vld, dp_rd_vld} !== 2'b00) begin
        n_err++;
        $display("FAIL rst_no_vld i%0d: vld %b want 00", i, {reg_rd_vld, dp_rd_vld});
      end
      step();
      reg_wr_req = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_reg_read();
    test_reg_write();
    test_weighted();
    test_dp_rd_wr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
